track_corr_bank: RTL and testbench

Parametrised multi-tap correlator bank for one tracking channel. It accumulates carrier-wiped I/Q baseband samples against NUM_TAPS delayed copies of the C/A code (early…late). At each code epoch it dumps all tap accumulations, plus the epoch's sample count, through a valid/ack handshake to the loop-filter side. It replaces the single-prompt subchannel accumulation path in the tracking top.

---
 rtl/track_corr_bank.sv | 122 ++++++++++++
 tb/tb_track_corr_bank.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/track_corr_bank.sv
// Multi-tap early..late I/Q correlator bank with epoch dump handshake.
// TRACK_CORR_BANK_SATURATE_EN: saturating accumulators (default wraps).
module track_corr_bank #(
  parameter int INPUT_WIDTH = 3,
  parameter int NUM_TAPS    = 3,
  parameter int TAP_SPACING = 8,
  parameter int ACC_WIDTH   = 24,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              sample_valid,
  input  logic signed [INPUT_WIDTH-1:0]     data_i,
  input  logic signed [INPUT_WIDTH-1:0]     data_q,
  input  logic                              ca_bit,
  input  logic                              epoch,
  input  logic                              dump_ack,
  output logic                              dump_valid,
  output logic [NUM_TAPS*ACC_WIDTH-1:0]     dump_i,
  output logic [NUM_TAPS*ACC_WIDTH-1:0]     dump_q,
  output logic [COUNT_WIDTH-1:0]            dump_count,
  output logic                              overrun
);

  localparam int L  = (NUM_TAPS - 1) * TAP_SPACING;
  localparam int DL = (L > 0) ? L : 1;

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  logic [DL-1:0]          d;
  logic [NUM_TAPS-1:0]    code;
  acc_t                   acc_i  [NUM_TAPS];
  acc_t                   acc_q  [NUM_TAPS];
  acc_t                   prod_i [NUM_TAPS];
  acc_t                   prod_q [NUM_TAPS];
  acc_t                   sum_i  [NUM_TAPS];
  acc_t                   sum_q  [NUM_TAPS];
  acc_t                   ext_i;
  acc_t                   ext_q;
  logic [COUNT_WIDTH-1:0] count;
  logic                   dump_fire;

  function automatic acc_t acc_add(input acc_t a, input acc_t b);
    acc_t s;
    s = a + b;
`ifdef TRACK_CORR_BANK_SATURATE_EN
    if (a[ACC_WIDTH-1] == b[ACC_WIDTH-1] &&
        s[ACC_WIDTH-1] != a[ACC_WIDTH-1])
      s = a[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
`endif
    return s;
  endfunction

  assign ext_i = {{(ACC_WIDTH-INPUT_WIDTH){data_i[INPUT_WIDTH-1]}}, data_i};
  assign ext_q = {{(ACC_WIDTH-INPUT_WIDTH){data_q[INPUT_WIDTH-1]}}, data_q};

  // Tap 0 sees the live chip; later taps read the pre-shift delay line.
  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    if (k == 0) begin : g_live
      assign code[k] = ca_bit;
    end else begin : g_del
      assign code[k] = d[k*TAP_SPACING-1];
    end
    assign prod_i[k] = code[k] ? -ext_i : ext_i;
    assign prod_q[k] = code[k] ? -ext_q : ext_q;
    assign sum_i[k]  = acc_add(acc_i[k], prod_i[k]);
    assign sum_q[k]  = acc_add(acc_q[k], prod_q[k]);
  end

  assign dump_fire = sample_valid & epoch;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d          <= '0;
      count      <= '0;
      dump_i     <= '0;
      dump_q     <= '0;
      dump_count <= '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        acc_i[k] <= '0;
        acc_q[k] <= '0;
      end
    end else if (sample_valid) begin
      d[0] <= ca_bit;
      for (int j = 1; j < DL; j++)
        d[j] <= d[j-1];
      if (epoch) begin
        dump_count <= count;
        count      <= COUNT_WIDTH'(1);
        for (int k = 0; k < NUM_TAPS; k++) begin
          dump_i[k*ACC_WIDTH +: ACC_WIDTH] <= acc_i[k];
          dump_q[k*ACC_WIDTH +: ACC_WIDTH] <= acc_q[k];
          acc_i[k] <= prod_i[k];
          acc_q[k] <= prod_q[k];
        end
      end else begin
        if (count != {COUNT_WIDTH{1'b1}})
          count <= count + COUNT_WIDTH'(1);
        for (int k = 0; k < NUM_TAPS; k++) begin
          acc_i[k] <= sum_i[k];
          acc_q[k] <= sum_q[k];
        end
      end
    end
  end

  // A new dump wins over a same-cycle ack; unacked overwrite is sticky.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dump_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (dump_fire) begin
      dump_valid <= 1'b1;
      if (dump_valid && !dump_ack)
        overrun <= 1'b1;
    end else if (dump_valid && dump_ack) begin
      dump_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_track_corr_bank.sv
// Directed bench for track_corr_bank: default instance plus
// an 8-bit accumulator instance for wrap/saturation checks.
module tb_track_corr_bank;

  localparam int IW  = 3;
  localparam int NT  = 3;
  localparam int TS  = 8;
  localparam int AW  = 24;
  localparam int AWS = 8;
  localparam int CW  = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sample_valid = 1'b0;
  logic ca_bit = 1'b0;
  logic epoch = 1'b0;
  logic dump_ack = 1'b0;
  logic signed [IW-1:0] data_i = '0;
  logic signed [IW-1:0] data_q = '0;

  logic            dump_valid, overrun;
  logic [NT*AW-1:0] dump_i, dump_q;
  logic [CW-1:0]   dump_count;
  logic            dump_valid_s, overrun_s;
  logic [NT*AWS-1:0] dump_i_s, dump_q_s;
  logic [CW-1:0]   dump_count_s;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  track_corr_bank #(
    .INPUT_WIDTH(IW), .NUM_TAPS(NT), .TAP_SPACING(TS),
    .ACC_WIDTH(AW), .COUNT_WIDTH(CW)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid),
    .data_i(data_i), .data_q(data_q), .ca_bit(ca_bit),
    .epoch(epoch), .dump_ack(dump_ack), .dump_valid(dump_valid),
    .dump_i(dump_i), .dump_q(dump_q), .dump_count(dump_count),
    .overrun(overrun)
  );

  track_corr_bank #(
    .INPUT_WIDTH(IW), .NUM_TAPS(NT), .TAP_SPACING(TS),
    .ACC_WIDTH(AWS), .COUNT_WIDTH(CW)
  ) dut_s (
    .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid),
    .data_i(data_i), .data_q(data_q), .ca_bit(ca_bit),
    .epoch(epoch), .dump_ack(dump_ack), .dump_valid(dump_valid_s),
    .dump_i(dump_i_s), .dump_q(dump_q_s), .dump_count(dump_count_s),
    .overrun(overrun_s)
  );

  task automatic cyc(input logic v, input int di, input int dq,
                     input logic ca, input logic ep, input logic ack);
    @(negedge clk);
    sample_valid = v;
    data_i = IW'(di);
    data_q = IW'(dq);
    ca_bit = ca;
    epoch = ep;
    dump_ack = ack;
  endtask

  task automatic idle();
    cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    idle();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 3, -2, i[0], 1'b1, i[1]);
    n_checks++;
    if (dump_valid !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got dv=%b ov=%b want 0 0",
               dump_valid, overrun);
    end
    n_checks++;
    if (dump_i !== '0 || dump_q !== '0 || dump_count !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got i=%h q=%h cnt=%0d want 0",
               dump_i, dump_q, dump_count);
    end
    n_checks++;
    if (dump_valid_s !== 1'b0 || dump_i_s !== '0) begin
      n_fail++;
      $display("FAIL reset_small: got dv=%b i=%h want 0",
               dump_valid_s, dump_i_s);
    end
    idle();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 1, 0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1, 0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (dump_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_early_dv: got %b want 0", dump_valid);
    end
    idle();
    n_checks++;
    if (dump_valid !== 1'b1 || dump_count !== CW'(5)) begin
      n_fail++;
      $display("FAIL reset_first_dump: got dv=%b cnt=%0d want 1 5",
               dump_valid, dump_count);
    end
    n_checks++;
    if (dump_i[AW +: AW] !== AW'(5)) begin
      n_fail++;
      $display("FAIL reset_first_tap1: got %0d want 5",
               $signed(dump_i[AW +: AW]));
    end
  endtask

  task automatic test_correlation();
    logic hist [1000];
    int exp_i [NT];
    int exp_q [NT];
    int di, dq, c;
    logic p;
    logic signed [AW-1:0] g;
    do_reset();
    for (int k = 0; k < NT; k++) begin
      exp_i[k] = 0;
      exp_q[k] = 0;
    end
    for (int n = 0; n < 1000; n++)
      hist[n] = 1'($urandom_range(0, 1));
    for (int n = 0; n < 1000; n++) begin
      p = (n >= TS) ? hist[n-TS] : 1'b0;
      di = p ? -3 : 3;
      dq = p ? 1 : -1;
      for (int k = 0; k < NT; k++) begin
        c = (n - TS*k >= 0) ? int'(hist[n-TS*k]) : 0;
        exp_i[k] += (c != 0) ? -di : di;
        exp_q[k] += (c != 0) ? -dq : dq;
      end
      cyc(1'b1, di, dq, hist[n], n == 0, 1'b0);
    end
    cyc(1'b1, 0, 0, 1'b0, 1'b1, 1'b0);
    idle();
    n_checks++;
    if (dump_count !== CW'(1000)) begin
      n_fail++;
      $display("FAIL corr_count: got %0d want 1000", dump_count);
    end
    g = dump_i[AW +: AW];
    n_checks++;
    if (g !== AW'(3000)) begin
      n_fail++;
      $display("FAIL corr_prompt_i: got %0d want 3000", g);
    end
    g = dump_q[AW +: AW];
    n_checks++;
    if (g !== AW'(-1000)) begin
      n_fail++;
      $display("FAIL corr_prompt_q: got %0d want -1000", g);
    end
    for (int k = 0; k < NT; k += 2) begin
      g = dump_i[k*AW +: AW];
      n_checks++;
      if (g !== AW'(exp_i[k])) begin
        n_fail++;
        $display("FAIL corr_tap%0d_i: got %0d want %0d", k, g, exp_i[k]);
      end
      g = dump_q[k*AW +: AW];
      n_checks++;
      if (g !== AW'(exp_q[k])) begin
        n_fail++;
        $display("FAIL corr_tap%0d_q: got %0d want %0d", k, g, exp_q[k]);
      end
    end
  endtask

  task automatic test_tap_spacing();
    logic signed [AW-1:0] g;
    int want;
    do_reset();
    for (int n = 0; n < 20; n++) begin
      cyc(1'b1, 1, 0, n == 0, 1'b1, 1'b1);
      if (n >= 2) begin
        for (int k = 0; k < NT; k++) begin
          want = (n - 2 == TS*k) ? -1 : 1;
          g = dump_i[k*AW +: AW];
          n_checks++;
          if (g !== AW'(want)) begin
            n_fail++;
            $display("FAIL tap_spacing s%0d k%0d: got %0d want %0d",
                     n - 2, k, g, want);
          end
        end
      end
    end
    idle();
    n_checks++;
    if (overrun !== 1'b0 || dump_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL tap_spacing_flags: got ov=%b dv=%b want 0 1",
               overrun, dump_valid);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    cyc(1'b1, 2, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < 10; i++)
      cyc(1'b1, 2, 0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (dump_valid !== 1'b1 || overrun !== 1'b0 || dump_count !== '0) begin
      n_fail++;
      $display("FAIL ovr_first: got dv=%b ov=%b cnt=%0d want 1 0 0",
               dump_valid, overrun, dump_count);
    end
    cyc(1'b1, 2, 0, 1'b0, 1'b1, 1'b0);
    idle();
    n_checks++;
    if (dump_valid !== 1'b1 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_flags: got dv=%b ov=%b want 1 1",
               dump_valid, overrun);
    end
    n_checks++;
    if (dump_count !== CW'(10) || dump_i[AW +: AW] !== AW'(20)) begin
      n_fail++;
      $display("FAIL ovr_data: got cnt=%0d i=%0d want 10 20",
               dump_count, $signed(dump_i[AW +: AW]));
    end
    cyc(1'b1, 2, 0, 1'b0, 1'b1, 1'b1);
    idle();
    n_checks++;
    if (dump_valid !== 1'b1 || overrun !== 1'b1 || dump_count !== CW'(1)) begin
      n_fail++;
      $display("FAIL ovr_sticky: got dv=%b ov=%b cnt=%0d want 1 1 1",
               dump_valid, overrun, dump_count);
    end
  endtask

  task automatic test_ack();
    do_reset();
    cyc(1'b1, 1, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1, 0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1, 0, 1'b0, 1'b1, 1'b1);
    idle();
    n_checks++;
    if (dump_valid !== 1'b1 || overrun !== 1'b0 || dump_count !== CW'(4)) begin
      n_fail++;
      $display("FAIL ack_same_cycle: got dv=%b ov=%b cnt=%0d want 1 0 4",
               dump_valid, overrun, dump_count);
    end
    cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    idle();
    n_checks++;
    if (dump_valid !== 1'b0 || dump_count !== CW'(4)) begin
      n_fail++;
      $display("FAIL ack_clear: got dv=%b cnt=%0d want 0 4",
               dump_valid, dump_count);
    end
    cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    idle();
    n_checks++;
    if (dump_valid !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_idle: got dv=%b ov=%b want 0 0",
               dump_valid, overrun);
    end
  endtask

  task automatic test_saturation();
    logic [AWS-1:0] want_i, want_q;
`ifdef TRACK_CORR_BANK_SATURATE_EN
    want_i = 8'h7f;
    want_q = 8'h80;
`else
    want_i = 8'h96;
    want_q = 8'h6a;
`endif
    do_reset();
    cyc(1'b1, 3, -3, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < 50; i++)
      cyc(1'b1, 3, -3, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 0, 0, 1'b0, 1'b1, 1'b0);
    idle();
    n_checks++;
    if (dump_count_s !== CW'(50) || dump_i[AW +: AW] !== AW'(150)) begin
      n_fail++;
      $display("FAIL sat_wide: got cnt=%0d i=%0d want 50 150",
               dump_count_s, $signed(dump_i[AW +: AW]));
    end
    n_checks++;
    if (dump_i_s[AWS +: AWS] !== want_i) begin
      n_fail++;
      $display("FAIL sat_pos: got %h want %h", dump_i_s[AWS +: AWS], want_i);
    end
    n_checks++;
    if (dump_q_s[AWS +: AWS] !== want_q) begin
      n_fail++;
      $display("FAIL sat_neg: got %h want %h", dump_q_s[AWS +: AWS], want_q);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    cyc(1'b1, 1, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < 500; i++)
      cyc(1'b1, 1, 0, 1'b0, 1'b0, 1'b0);
    idle();
    n_checks++;
    if (dump_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: got dv=%b want 1", dump_valid);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (dump_valid !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_async: got dv=%b ov=%b want 0 0",
               dump_valid, overrun);
    end
    idle();
    reset_n = 1'b1;
    for (int i = 0; i < 7; i++)
      cyc(1'b1, 1, 0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1, 0, 1'b0, 1'b1, 1'b0);
    idle();
    n_checks++;
    if (dump_count !== CW'(7) || dump_i[AW +: AW] !== AW'(7)) begin
      n_fail++;
      $display("FAIL mid_after: got cnt=%0d i=%0d want 7 7",
               dump_count, $signed(dump_i[AW +: AW]));
    end
  endtask

  initial begin
    test_reset();
    test_correlation();
    test_tap_spacing();
    test_overrun();
    test_ack();
    test_saturation();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
